uart_tx: RTL

Serial transmitter paired with the existing UART receiver. Accepts parallel words over a valid/ready handshake, buffers one word, and shifts frames out LSB-first. Frame format: start bit, data bits, optional parity, stop bit(s). Bit timing comes from the shared baud enable pulse, the same `baud_clk_en` that drives the receiver, so the block holds no baud counter of its own.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to transmitter and receiver),
// parity mode constants and a parity helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } uart_state_e;

    // Data must be zero-extended to 8 bits; unused upper bits then do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding register in front of an LSB-first shifter,
// stepped only by the shared baud enable pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [2:0]           dbg_state_o
);

    // Handshake: a word transfers on a clk edge where tx_valid && tx_ready; tx_ready is
    // a flop mirroring "holding register empty", so it never depends on tx_valid.

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_out_q, tx_out_d;
    logic                 done_q, done_d;
    logic                 busy_q;
    logic                 ready_q;
    logic                 accept;
    logic                 take;

    assign accept      = tx_valid && ready_q;
    assign tx_ready    = ready_q;
    assign tx_out      = tx_out_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_out_d   = tx_out_q;
        done_d     = 1'b0;
        take       = 1'b0;
        if (baud_clk_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        take     = 1'b1;
                        state_d  = S_START;
                        tx_out_d = 1'b0;
                    end
                end
                S_START: begin
                    state_d   = S_DATA;
                    tx_out_d  = shift_q[0];
                    bit_cnt_d = 3'd0;
                end
                S_DATA: begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_d  = S_PARITY;
                            tx_out_d = par_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_out_d   = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_out_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    tx_out_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        // A waiting word starts immediately: no idle bit between frames.
                        if (hold_full_q) begin
                            take     = 1'b1;
                            state_d  = S_START;
                            tx_out_d = 1'b0;
                        end else begin
                            state_d  = S_IDLE;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    tx_out_d = 1'b1;
                end
            endcase
        end
        if (take) begin
            shift_d = hold_q;
            par_d   = parity_bit(8'(hold_q), PARITY);
        end
        // take and accept are exclusive: take needs a full register, accept an empty one.
        hold_full_d = take ? 1'b0 : (accept ? 1'b1 : hold_full_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            tx_out_q    <= 1'b1;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            if (accept) hold_q <= data_in;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_out_q    <= tx_out_d;
            done_q      <= done_d;
            busy_q      <= (state_d != S_IDLE);
            ready_q     <= !hold_full_d;
        end
    end

endmodule
